// File: rtl/gray_pkg.sv
// Shared types and helpers for the serial Gray encoder/decoder pair.
package gray_pkg;

  localparam int WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    S_MSB = 2'd0,
    S_MID = 2'd1,
    S_LSB = 2'd2
  } state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin_gray_serial_fsm_if.sv
// Serial bit stream in, serial Gray stream plus assembled word out.
interface bin_gray_serial_fsm_if #(
  parameter int WIDTH = gray_pkg::WIDTH_DEF
) ();

  logic             in_valid;
  logic             in;
  logic             out_valid;
  logic             out;
  logic             frame_first;
  logic             word_valid;
  logic [WIDTH-1:0] word_out;

  modport master (
    output in_valid, in,
    input  out_valid, out, frame_first, word_valid, word_out
  );

  modport slave (
    input  in_valid, in,
    output out_valid, out, frame_first, word_valid, word_out
  );

endinterface

// File: rtl/bin_gray_serial_fsm.sv
// Serial MSB-first binary-to-Gray encoder with parallel word assembly; one cycle latency.
// No backpressure: a bit is consumed on every in_valid edge, stalls simply hold state.
module bin_gray_serial_fsm
  import gray_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  bin_gray_serial_fsm_if.slave  bus
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic             prev, prev_nxt;
  logic             gbit;
  logic             last;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] shift_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_MSB;
      idx   <= '0;
      prev  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      prev  <= prev_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    prev_nxt  = prev;
    last      = 1'b0;
    // MSB never looks at prev, so a stale value can't leak across frames
    gbit      = (state == S_MSB) ? bus.in : (bus.in ^ prev);
    case (state)
      S_MSB: begin
        if (bus.in_valid) begin
          state_nxt = (WIDTH == 2) ? S_LSB : S_MID;
          idx_nxt   = IW'(1);
          prev_nxt  = bus.in;
        end
      end
      S_MID: begin
        if (bus.in_valid) begin
          idx_nxt  = idx + IW'(1);
          prev_nxt = bus.in;
          if (idx == IW'(WIDTH - 2)) state_nxt = S_LSB;
        end
      end
      S_LSB: begin
        if (bus.in_valid) begin
          state_nxt = S_MSB;
          idx_nxt   = '0;
          prev_nxt  = 1'b0;
          last      = 1'b1;
        end
      end
      default: begin
        state_nxt = S_MSB;
        idx_nxt   = '0;
        prev_nxt  = 1'b0;
      end
    endcase
  end

  assign shift_nxt = {shreg, gbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out         <= 1'b0;
      bus.frame_first <= 1'b0;
      bus.word_valid  <= 1'b0;
      bus.word_out    <= '0;
      shreg           <= '0;
    end else begin
      bus.out_valid   <= bus.in_valid;
      bus.frame_first <= bus.in_valid && (state == S_MSB);
      bus.word_valid  <= last;
      if (bus.in_valid) begin
        bus.out <= gbit;
        shreg   <= shift_nxt[WIDTH-2:0];
      end
      if (last) bus.word_out <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_bin_gray_serial_fsm.sv
// Directed bench for the serial binary-to-Gray encoder (WIDTH=5).
module tb_bin_gray_serial_fsm;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  bin_gray_serial_fsm_if #(.WIDTH(W)) intf ();

  bin_gray_serial_fsm #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // apply one input cycle, then land on the following negedge to sample
  task automatic drive(input logic v, input logic b);
    intf.in_valid = v;
    intf.in       = b;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stall_chk(input string tag, input logic out_hold, input logic [W-1:0] word_hold);
    drive(1'b0, 1'b0);
    chk({tag, ".out_valid"},   32'(intf.out_valid),   32'd0);
    chk({tag, ".frame_first"}, 32'(intf.frame_first), 32'd0);
    chk({tag, ".word_valid"},  32'(intf.word_valid),  32'd0);
    chk({tag, ".out_hold"},    32'(intf.out),         32'(out_hold));
    chk({tag, ".word_hold"},   32'(intf.word_out),    32'(word_hold));
  endtask

  task automatic bit_chk(input string tag, input logic b, input logic g, input int pos,
                         input logic [W-1:0] gword, input logic [W-1:0] old_word);
    drive(1'b1, b);
    chk({tag, ".out_valid"},   32'(intf.out_valid),   32'd1);
    chk({tag, ".out"},         32'(intf.out),         32'(g));
    chk({tag, ".frame_first"}, 32'(intf.frame_first), (pos == W-1) ? 32'd1 : 32'd0);
    chk({tag, ".word_valid"},  32'(intf.word_valid),  (pos == 0) ? 32'd1 : 32'd0);
    chk({tag, ".word_out"},    32'(intf.word_out),    (pos == 0) ? 32'(gword) : 32'(old_word));
  endtask

  task automatic frame(input string tag, input logic [W-1:0] bin, input logic [W-1:0] gword,
                       input logic [W-1:0] old_word);
    for (int i = W-1; i >= 0; i--)
      bit_chk($sformatf("%s.b%0d", tag, i), bin[i], gword[i], i, gword, old_word);
  endtask

  initial begin
    rst = 1'b1;
    intf.in_valid = 1'b0;
    intf.in       = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b0);
    chk("rst.out_valid",   32'(intf.out_valid),   32'd0);
    chk("rst.out",         32'(intf.out),         32'd0);
    chk("rst.frame_first", 32'(intf.frame_first), 32'd0);
    chk("rst.word_valid",  32'(intf.word_valid),  32'd0);
    chk("rst.word_out",    32'(intf.word_out),    32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0);
      chk("idle.out_valid",  32'(intf.out_valid),  32'd0);
      chk("idle.word_valid", 32'(intf.word_valid), 32'd0);
      chk("idle.word_out",   32'(intf.word_out),   32'd0);
    end

    frame("f10110", 5'b10110, 5'b11101, 5'b00000);
    stall_chk("post10110", 1'b1, 5'b11101);

    // back-to-back: prev must clear at the frame boundary
    frame("f00001", 5'b00001, 5'b00001, 5'b11101);
    frame("f10000", 5'b10000, 5'b11000, 5'b00001);

    // 01011 with two-cycle stalls after bits 2 and 4
    bit_chk("s.b4", 1'b0, 1'b0, 4, 5'b01110, 5'b11000);
    bit_chk("s.b3", 1'b1, 1'b1, 3, 5'b01110, 5'b11000);
    stall_chk("s.st1a", 1'b1, 5'b11000);
    stall_chk("s.st1b", 1'b1, 5'b11000);
    bit_chk("s.b2", 1'b0, 1'b1, 2, 5'b01110, 5'b11000);
    bit_chk("s.b1", 1'b1, 1'b1, 1, 5'b01110, 5'b11000);
    stall_chk("s.st2a", 1'b1, 5'b11000);
    stall_chk("s.st2b", 1'b1, 5'b11000);
    bit_chk("s.b0", 1'b1, 1'b0, 0, 5'b01110, 5'b11000);

    frame("f11111", 5'b11111, 5'b10000, 5'b01110);
    frame("f00000", 5'b00000, 5'b00000, 5'b10000);

    // partial frame 111 then reset (asserted together with a valid bit)
    frame("f10110b", 5'b10110, 5'b11101, 5'b00000);
    bit_chk("p.b4", 1'b1, 1'b1, 4, 5'b00000, 5'b11101);
    bit_chk("p.b3", 1'b1, 1'b0, 3, 5'b00000, 5'b11101);
    bit_chk("p.b2", 1'b1, 1'b0, 2, 5'b00000, 5'b11101);
    rst = 1'b1;
    drive(1'b1, 1'b1);
    chk("prst.out_valid",  32'(intf.out_valid),  32'd0);
    chk("prst.word_valid", 32'(intf.word_valid), 32'd0);
    chk("prst.word_out",   32'(intf.word_out),   32'd0);
    rst = 1'b0;
    frame("f01011", 5'b01011, 5'b01110, 5'b00000);
    stall_chk("end", 1'b0, 5'b01110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
